// File: rtl/kv_pkg.sv
// kv_pkg
// Shared types and constants for the key-value store front-end.
//   kv_op_e    : request opcode encoding carried on req_op
//   kv_state_e : controller FSM states
//   EMPTY_KEY  : key value that marks an empty cell and is never stored
package kv_pkg;

  typedef enum logic [1:0] {
    OP_GET  = 2'b00,
    OP_PUT  = 2'b01,
    OP_DEL  = 2'b10,
    OP_RSVD = 2'b11
  } kv_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOOKUP = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } kv_state_e;

  localparam int unsigned EMPTY_KEY = 0;

endpackage

// File: rtl/kv_match_unit.sv
// kv_match_unit
// Combinational parallel search across all cells.
//   key          : key being looked up
//   cell_key_out : packed keys of all cells, cell i at [i*KEY_WIDTH +: KEY_WIDTH]
//   cell_used    : per-cell occupancy
//   hit          : some used cell holds key
//   match_idx    : lowest used cell holding key (0 when no hit)
//   have_free    : at least one cell is unused
//   free_idx     : lowest unused cell (0 when none)
module kv_match_unit
  import kv_pkg::*;
#(
  parameter int NUM_CELLS = 8,
  parameter int KEY_WIDTH = 8,
  parameter int IDX_WIDTH = $clog2(NUM_CELLS)
) (
  input  logic [KEY_WIDTH-1:0]           key,
  input  logic [NUM_CELLS*KEY_WIDTH-1:0] cell_key_out,
  input  logic [NUM_CELLS-1:0]           cell_used,
  output logic                           hit,
  output logic [IDX_WIDTH-1:0]           match_idx,
  output logic                           have_free,
  output logic [IDX_WIDTH-1:0]           free_idx
);

  // Scan from the top down so the last assignment, and therefore the
  // winner, is always the lowest matching / lowest free index.
  always_comb begin
    hit       = 1'b0;
    match_idx = '0;
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (cell_used[i] && (cell_key_out[i*KEY_WIDTH +: KEY_WIDTH] == key)) begin
        hit       = 1'b1;
        match_idx = IDX_WIDTH'(i);
      end
      if (!cell_used[i]) begin
        have_free = 1'b1;
        free_idx  = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/kv_store_ctrl.sv
// kv_store_ctrl
// Command front-end for the key-value cell array: one GET/PUT/DEL at a time,
// parallel lookup, free-cell allocation and per-cell write strobes.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake; req_op, req_key, req_value payload
//   resp_valid/resp_ready: response handshake; resp_hit, resp_err, resp_value
//   cell_write_op        : one-hot write strobe, high for the single WRITE cycle
//   cell_key_in/value_in : shared write buses (0 when not writing)
//   cell_key_out/value_out/used : read-back of every cell
//   count, full          : occupancy tracking
module kv_store_ctrl
  import kv_pkg::*;
#(
  parameter int NUM_CELLS   = 8,
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [1:0]                         req_op,
  input  logic [KEY_WIDTH-1:0]               req_key,
  input  logic [VALUE_WIDTH-1:0]             req_value,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic                               resp_hit,
  output logic                               resp_err,
  output logic [VALUE_WIDTH-1:0]             resp_value,
  output logic [NUM_CELLS-1:0]               cell_write_op,
  output logic [KEY_WIDTH-1:0]               cell_key_in,
  output logic [VALUE_WIDTH-1:0]             cell_value_in,
  input  logic [NUM_CELLS*KEY_WIDTH-1:0]     cell_key_out,
  input  logic [NUM_CELLS*VALUE_WIDTH-1:0]   cell_value_out,
  input  logic [NUM_CELLS-1:0]               cell_used,
  output logic [$clog2(NUM_CELLS+1)-1:0]     count,
  output logic                               full
);

  localparam int IDX_WIDTH   = $clog2(NUM_CELLS);
  localparam int COUNT_WIDTH = $clog2(NUM_CELLS + 1);

  kv_state_e               state;
  kv_op_e                  op_q;
  logic [KEY_WIDTH-1:0]    key_q;
  logic [VALUE_WIDTH-1:0]  value_q;
  logic [IDX_WIDTH-1:0]    target_q;
  logic                    hit_q;
  logic                    err_q;
  logic [VALUE_WIDTH-1:0]  resp_value_q;
  logic [COUNT_WIDTH-1:0]  count_q;

  logic                    match_hit;
  logic [IDX_WIDTH-1:0]    match_idx;
  logic                    have_free;
  logic [IDX_WIDTH-1:0]    free_idx;
  logic [VALUE_WIDTH-1:0]  match_value;
  logic                    req_bad;

  kv_match_unit #(
    .NUM_CELLS (NUM_CELLS),
    .KEY_WIDTH (KEY_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_match (
    .key          (key_q),
    .cell_key_out (cell_key_out),
    .cell_used    (cell_used),
    .hit          (match_hit),
    .match_idx    (match_idx),
    .have_free    (have_free),
    .free_idx     (free_idx)
  );

  assign match_value = cell_value_out[match_idx*VALUE_WIDTH +: VALUE_WIDTH];
  assign req_bad     = (key_q == KEY_WIDTH'(EMPTY_KEY)) || (op_q == OP_RSVD);

  // Request FSM. Response fields are cleared on accept so that anything not
  // explicitly set during LOOKUP reads back as 0. The count only moves in
  // WRITE, and WRITE is only reachable for a PUT with room or a DEL hit, so
  // the counter can neither overflow nor underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= OP_GET;
      key_q        <= '0;
      value_q      <= '0;
      target_q     <= '0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      resp_value_q <= '0;
      count_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q         <= kv_op_e'(req_op);
            key_q        <= req_key;
            value_q      <= req_value;
            hit_q        <= 1'b0;
            err_q        <= 1'b0;
            resp_value_q <= '0;
            state        <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q <= match_hit;
          if (req_bad) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            case (op_q)
              OP_GET: begin
                if (match_hit) resp_value_q <= match_value;
                state <= RESP;
              end
              OP_PUT: begin
                if (match_hit) begin
                  target_q <= match_idx;
                  state    <= WRITE;
                end else if (have_free) begin
                  target_q <= free_idx;
                  state    <= WRITE;
                end else begin
                  err_q <= 1'b1;
                  state <= RESP;
                end
              end
              OP_DEL: begin
                if (match_hit) begin
                  target_q <= match_idx;
                  state    <= WRITE;
                end else begin
                  state <= RESP;
                end
              end
              default: begin
                err_q <= 1'b1;
                state <= RESP;
              end
            endcase
          end
        end
        WRITE: begin
          if ((op_q == OP_PUT) && !hit_q) count_q <= count_q + COUNT_WIDTH'(1);
          else if (op_q == OP_DEL)        count_q <= count_q - COUNT_WIDTH'(1);
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write buses are decoded straight from the state so the strobe vanishes
  // the instant reset asserts; DEL writes key 0 to free the cell.
  always_comb begin
    cell_write_op = '0;
    cell_key_in   = '0;
    cell_value_in = '0;
    if (state == WRITE) begin
      cell_write_op[target_q] = 1'b1;
      if (op_q == OP_PUT) begin
        cell_key_in   = key_q;
        cell_value_in = value_q;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_hit   = hit_q;
  assign resp_err   = err_q;
  assign resp_value = resp_value_q;
  assign count      = count_q;
  assign full       = (count_q == COUNT_WIDTH'(NUM_CELLS));

endmodule

// File: tb/tb_kv_store_ctrl.sv
// tb_kv_store_ctrl
// Self-checking bench for kv_store_ctrl: a simple behavioural cell array
// answers the controller, and a slot-table reference model predicts every
// response, write strobe and occupancy value.
module tb_kv_store_ctrl;
  import kv_pkg::*;

  localparam int NUM_CELLS   = 8;
  localparam int KEY_WIDTH   = 8;
  localparam int VALUE_WIDTH = 64;
  localparam int CW          = $clog2(NUM_CELLS + 1);

  logic                             clk = 1'b0;
  logic                             rst_n = 1'b0;
  logic                             req_valid;
  logic                             req_ready;
  logic [1:0]                       req_op;
  logic [KEY_WIDTH-1:0]             req_key;
  logic [VALUE_WIDTH-1:0]           req_value;
  logic                             resp_valid;
  logic                             resp_ready;
  logic                             resp_hit;
  logic                             resp_err;
  logic [VALUE_WIDTH-1:0]           resp_value;
  logic [NUM_CELLS-1:0]             cell_write_op;
  logic [KEY_WIDTH-1:0]             cell_key_in;
  logic [VALUE_WIDTH-1:0]           cell_value_in;
  logic [NUM_CELLS*KEY_WIDTH-1:0]   cell_key_out;
  logic [NUM_CELLS*VALUE_WIDTH-1:0] cell_value_out;
  logic [NUM_CELLS-1:0]             cell_used;
  logic [CW-1:0]                    count;
  logic                             full;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  kv_store_ctrl #(
    .NUM_CELLS   (NUM_CELLS),
    .KEY_WIDTH   (KEY_WIDTH),
    .VALUE_WIDTH (VALUE_WIDTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_key        (req_key),
    .req_value      (req_value),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_hit       (resp_hit),
    .resp_err       (resp_err),
    .resp_value     (resp_value),
    .cell_write_op  (cell_write_op),
    .cell_key_in    (cell_key_in),
    .cell_value_in  (cell_value_in),
    .cell_key_out   (cell_key_out),
    .cell_value_out (cell_value_out),
    .cell_used      (cell_used),
    .count          (count),
    .full           (full)
  );

  // Behavioural cell array; it is cleared together with the controller.
  logic [KEY_WIDTH-1:0]   arr_key [NUM_CELLS];
  logic [VALUE_WIDTH-1:0] arr_val [NUM_CELLS];
  logic [NUM_CELLS-1:0]   arr_used;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        arr_key[i] <= '0;
        arr_val[i] <= '0;
      end
      arr_used <= '0;
    end else begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (cell_write_op[i]) begin
          arr_key[i]  <= cell_key_in;
          arr_val[i]  <= cell_value_in;
          arr_used[i] <= (cell_key_in != '0);
        end
      end
    end
  end

  always_comb begin
    cell_key_out   = '0;
    cell_value_out = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      cell_key_out[i*KEY_WIDTH +: KEY_WIDTH]       = arr_key[i];
      cell_value_out[i*VALUE_WIDTH +: VALUE_WIDTH] = arr_val[i];
    end
    cell_used = arr_used;
  end

  // Strobe monitor: records each write cycle and flags malformed bus activity.
  int                     pulses = 0;
  int                     bus_errs = 0;
  logic [NUM_CELLS-1:0]   seen_strobe = '0;
  logic [KEY_WIDTH-1:0]   seen_key = '0;
  logic [VALUE_WIDTH-1:0] seen_val = '0;

  always @(negedge clk) begin
    if (cell_write_op != '0) begin
      pulses      = pulses + 1;
      seen_strobe = cell_write_op;
      seen_key    = cell_key_in;
      seen_val    = cell_value_in;
      if ($countones(cell_write_op) != 1) bus_errs = bus_errs + 1;
    end else if ((cell_key_in != '0) || (cell_value_in != '0)) begin
      bus_errs = bus_errs + 1;
    end
  end

  // Reference model: a slot table where key 0 means the slot is empty.
  logic [KEY_WIDTH-1:0]   m_key [NUM_CELLS];
  logic [VALUE_WIDTH-1:0] m_val [NUM_CELLS];
  int                     m_count;

  task automatic model_clear();
    for (int i = 0; i < NUM_CELLS; i++) begin
      m_key[i] = '0;
      m_val[i] = '0;
    end
    m_count = 0;
  endtask

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: predict, issue, time the response, check it,
  // optionally stall resp_ready for 'hold' cycles, then retire it.
  task automatic apply_stimulus(input logic [1:0] op, input logic [KEY_WIDTH-1:0] key,
                                input logic [VALUE_WIDTH-1:0] value, input int hold);
    int                     idx;
    int                     free;
    int                     n;
    int                     p0;
    bit                     e_hit;
    bit                     e_err;
    logic [VALUE_WIDTH-1:0] e_value;
    logic [NUM_CELLS-1:0]   e_strobe;
    logic [KEY_WIDTH-1:0]   e_bkey;
    logic [VALUE_WIDTH-1:0] e_bval;

    idx  = -1;
    free = -1;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (key != '0 && m_key[i] == key && idx < 0) idx = i;
      if (m_key[i] == '0 && free < 0) free = i;
    end
    e_hit    = (idx >= 0);
    e_err    = 1'b0;
    e_value  = '0;
    e_strobe = '0;
    e_bkey   = '0;
    e_bval   = '0;
    if (key == '0 || op == 2'b11) begin
      e_err = 1'b1;
    end else if (op == 2'b00) begin
      if (e_hit) e_value = m_val[idx];
    end else if (op == 2'b01) begin
      if (e_hit) begin
        e_strobe = NUM_CELLS'(1) << idx;
        m_val[idx] = value;
      end else if (free >= 0) begin
        e_strobe = NUM_CELLS'(1) << free;
        m_key[free] = key;
        m_val[free] = value;
        m_count = m_count + 1;
      end else begin
        e_err = 1'b1;
      end
      if (e_strobe != '0) begin
        e_bkey = key;
        e_bval = value;
      end
    end else begin
      if (e_hit) begin
        e_strobe = NUM_CELLS'(1) << idx;
        m_key[idx] = '0;
        m_val[idx] = '0;
        m_count = m_count - 1;
      end
    end

    p0 = pulses;
    @(negedge clk);
    check_output("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    req_value = value;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = '0;
    req_key   = '0;
    req_value = '0;

    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_output("latency", 64'(n + 1), (e_strobe != '0) ? 64'd3 : 64'd2);
    check_output("resp_hit", 64'(resp_hit), 64'(e_hit));
    check_output("resp_err", 64'(resp_err), 64'(e_err));
    check_output("resp_value", resp_value, e_value);
    check_output("req_ready_busy", 64'(req_ready), 64'd0);
    check_output("strobe_pulses", 64'(pulses - p0), (e_strobe != '0) ? 64'd1 : 64'd0);
    if (e_strobe != '0) begin
      check_output("strobe", 64'(seen_strobe), 64'(e_strobe));
      check_output("key_bus", 64'(seen_key), 64'(e_bkey));
      check_output("value_bus", seen_val, e_bval);
    end
    check_output("count", 64'(count), 64'(m_count));
    check_output("full", 64'(full), 64'(m_count == NUM_CELLS));

    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check_output("hold_valid", 64'(resp_valid), 64'd1);
      check_output("hold_value", resp_value, e_value);
      check_output("hold_err", 64'(resp_err), 64'(e_err));
      check_output("hold_ready", 64'(req_ready), 64'd0);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    req_valid  = 1'b0;
    req_op     = '0;
    req_key    = '0;
    req_value  = '0;
    resp_ready = 1'b0;
    model_clear();

    #2;
    check_output("rst_req_ready", 64'(req_ready), 64'd1);
    check_output("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_output("rst_count", 64'(count), 64'd0);
    check_output("rst_full", 64'(full), 64'd0);
    check_output("rst_strobe", 64'(cell_write_op), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios
    apply_stimulus(2'b00, 8'h05, 64'h0, 0);
    apply_stimulus(2'b01, 8'h05, 64'h1122334455667788, 0);
    apply_stimulus(2'b00, 8'h05, 64'h0, 0);
    apply_stimulus(2'b01, 8'h05, 64'hAA, 0);
    apply_stimulus(2'b00, 8'h05, 64'h0, 0);
    for (int k = 1; k <= 8; k++) apply_stimulus(2'b01, 8'(k), 64'(k * 64'h1001), 0);
    apply_stimulus(2'b01, 8'h09, 64'h99, 0);
    apply_stimulus(2'b10, 8'h03, 64'h0, 0);
    apply_stimulus(2'b01, 8'h0A, 64'hA0A0, 0);
    apply_stimulus(2'b01, 8'h00, 64'h1234, 0);
    apply_stimulus(2'b11, 8'h07, 64'h5678, 0);
    apply_stimulus(2'b00, 8'h0A, 64'h0, 5);

    // Reset while a PUT-hit on key 0x07 (cell 6) is in its WRITE cycle
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_key   = 8'h07;
    req_value = 64'hDEAD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = '0;
    req_key   = '0;
    req_value = '0;
    @(posedge clk);
    #1;
    check_output("write_before_rst", 64'(cell_write_op), 64'h40);
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_strobe", 64'(cell_write_op), 64'd0);
    check_output("rst_mid_count", 64'(count), 64'd0);
    check_output("rst_mid_ready", 64'(req_ready), 64'd1);
    check_output("rst_mid_valid", 64'(resp_valid), 64'd0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic over a small key space to force hits, fills and deletes
    for (int t = 0; t < 300; t++) begin
      apply_stimulus(2'($urandom_range(0, 3)), 8'($urandom_range(0, 12)),
                     {$urandom(), $urandom()}, int'($urandom_range(0, 2)));
    end

    check_output("bus_idle_onehot", 64'(bus_errs), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kv_store_ctrl.md
Name: kv_store_ctrl

Overview:
Command front-end for the key-value cell array. It accepts GET/PUT/DEL requests over a valid/ready handshake and searches every cell's key, value and used outputs in parallel. It allocates free cells and drives the per-cell write strobes and the shared key/value write buses. It sits directly upstream of the cell array, and the cell array is the only storage.

Parameters:
NUM_CELLS, 8, number of cells in the array (>=2)
KEY_WIDTH, 8, key width; key value 0 is reserved and means an empty cell
VALUE_WIDTH, 64, value width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
req_op  in  2  00 GET, 01 PUT, 10 DEL, 11 reserved
req_key  in  KEY_WIDTH  request key
req_value  in  VALUE_WIDTH  PUT data
resp_valid  out  1  response valid
resp_ready  in  1  response consumed
resp_hit  out  1  key was present before this op
resp_err  out  1  op rejected (full, key 0, or op 11)
resp_value  out  VALUE_WIDTH  GET data on hit, else 0
cell_write_op  out  NUM_CELLS  one-hot write strobe per cell
cell_key_in  out  KEY_WIDTH  shared key write bus
cell_value_in  out  VALUE_WIDTH  shared value write bus
cell_key_out  in  NUM_CELLS*KEY_WIDTH  cell i key at [i*KEY_WIDTH +: KEY_WIDTH]
cell_value_out  in  NUM_CELLS*VALUE_WIDTH  cell i value, same packing
cell_used  in  NUM_CELLS  cell i holds a valid key
count  out  $clog2(NUM_CELLS+1)  number of used cells
full  out  1  count == NUM_CELLS

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - All outputs are 0, except req_ready=1.
  - count=0.
  - Any in-flight request is dropped and no write strobe fires.
- The controller is not pipelined: one request is in flight at a time, and req_ready=1 only in IDLE.
- IDLE:
  - On acceptance, register op, key and value, then go to LOOKUP.
- LOOKUP (1 cycle):
  - Match vector: cell_used[i] && key_out[i]==key. The lowest matching index wins.
  - Free index: lowest i with !cell_used[i].
  - Register hit, match_idx, free_idx and have_free.
  - Decide the outcome:
    - Key 0 or op 11: err=1, go to RESP.
    - GET: go to RESP. resp_value = value of the matched cell if hit, else 0.
    - PUT hit: target = match_idx, go to WRITE.
    - PUT miss with a free cell: target = free_idx, go to WRITE.
    - PUT miss with no free cell: err=1, go to RESP, no write.
    - DEL hit: target = match_idx, go to WRITE.
    - DEL miss: go to RESP with hit=0, no write.
- WRITE (1 cycle):
  - cell_write_op[target]=1 for exactly this cycle.
  - PUT drives key and value onto cell_key_in/cell_value_in. DEL drives 0 and 0.
  - count updates at the end of WRITE: +1 on PUT-miss, -1 on DEL-hit, unchanged on PUT-hit.
  - Go to RESP.
- RESP:
  - resp_valid=1. All resp_* outputs are registered and stable until resp_ready.
  - The resp_valid && resp_ready edge returns to IDLE.
- Latency from the accept edge to resp_valid high:
  - GET or error: 2 cycles.
  - PUT/DEL with a write: 3 cycles.
- Bus idle values: cell_write_op=0 outside WRITE; cell_key_in/cell_value_in=0 outside WRITE.
- Width and range rules:
  - count never wraps. The saturation guards are structural: PUT-miss is only possible when free, DEL only when hit.
  - full is combinational from count.
- Duplicate keys cannot arise, because a PUT always checks for a match before allocating.

Decomposition:
- Package kv_pkg:
  - kv_op_e: OP_GET, OP_PUT, OP_DEL, OP_RSVD.
  - kv_state_e: IDLE, LOOKUP, WRITE, RESP.
  - Constant EMPTY_KEY='0.
- Sub-module kv_match_unit (combinational, parameterised):
  - Inputs: key, cell_key_out, cell_used.
  - Outputs: hit, match_idx, have_free, free_idx. Both indices use lowest-index priority.
- The FSM, counter and response registers live in kv_store_ctrl.

Test Plan:
1. Reset, then GET 0x05 -> resp_valid 2 cycles after accept; hit=0, err=0, value=0; no cell_write_op pulse.
2. PUT 0x05/0x1122334455667788 into an empty array -> cell_write_op=0x01 for one cycle with those buses; resp hit=0; count=1. Then GET 0x05 -> hit=1, value 0x1122334455667788.
3. PUT 0x05/0xAA -> cell_write_op=0x01 again; resp hit=1; count stays 1; GET returns 0xAA.
4. PUT keys 0x01..0x08 -> full=1, count=8. Then PUT 0x09 -> err=1, no strobe, count=8.
5. DEL the key in cell 3 -> cell_write_op=0x08 with key 0 and value 0; hit=1; count=7. Next PUT 0x0A -> allocates cell 3 (0x08); count=8.
6. Error and robustness cases:
   - PUT key 0 -> err=1, no write.
   - op 11 -> err=1, no write.
   - resp_ready held low 5 cycles -> resp stable, req_ready=0.
   - rst_n low during WRITE -> strobe drops immediately, count=0, req_ready=1.
